// File: rtl/pong_pkg.sv
// Shared types and default speed constants for the pong ball controller.
// Holds the FSM state enum plus helper functions for score and speed updates.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam logic [63:0] DEF_THRESH_INIT = 64'd500000;
  localparam logic [63:0] DEF_THRESH_MIN  = 64'd100000;
  localparam logic [63:0] DEF_THRESH_STEP = 64'd25000;
  localparam logic [31:0] DEF_SCORE_HOLD  = 32'd50000000;

  // Saturating 4-bit score increment.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  // Shorten the mover wait, clamped at floor without wrapping.
  function automatic logic [63:0] speed_up(
    input logic [63:0] thr,
    input logic [63:0] step,
    input logic [63:0] floor
  );
    if (thr < step) return floor;
    if ((thr - step) < floor) return floor;
    return thr - step;
  endfunction

endpackage

// File: rtl/paddle_hit.sv
// Combinational check that ball_y lies within a paddle's vertical span.
// Ports: ball_y, paddle_y (paddle top) in; hit out.
module paddle_hit
  import pong_pkg::*;
#(
  parameter int cwidth   = 7,
  parameter int PADDLE_H = 16
) (
  input  logic [cwidth:0] ball_y,
  input  logic [cwidth:0] paddle_y,
  output logic            hit
);

  localparam int W = cwidth + 2;
  localparam logic [W-1:0] SPAN =
    W'((PADDLE_H > 0) ? PADDLE_H - 1 : 0);

  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] y;

  // One extra bit so paddle_y + span never wraps.
  assign lo  = {1'b0, paddle_y};
  assign y   = {1'b0, ball_y};
  assign hi  = lo + SPAN;
  assign hit = (PADDLE_H > 0) && (y >= lo) && (y <= hi);

endmodule

// File: rtl/bounce_controller.sv
// Pong ball controller: serve, wall/paddle bounces, speed-up and scoring.
// Ports: clock, reset, serve, ball/paddle coords in; active, directions, threshold, scores, point out.
module bounce_controller
  import pong_pkg::*;
#(
  parameter int          cwidth      = 7,
  parameter int          X_MAX       = 159,
  parameter int          Y_MAX       = 119,
  parameter int          LEFT_X      = 4,
  parameter int          RIGHT_X     = 155,
  parameter int          PADDLE_H    = 16,
  parameter logic [63:0] THRESH_INIT = DEF_THRESH_INIT,
  parameter logic [63:0] THRESH_MIN  = DEF_THRESH_MIN,
  parameter logic [63:0] THRESH_STEP = DEF_THRESH_STEP,
  parameter logic [31:0] SCORE_HOLD  = DEF_SCORE_HOLD
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            serve,
  input  logic [cwidth:0] ball_x,
  input  logic [cwidth:0] ball_y,
  input  logic [cwidth:0] paddle_l,
  input  logic [cwidth:0] paddle_r,
  output logic            active,
  output logic            direction_x,
  output logic            direction_y,
  output logic [63:0]     threshold,
  output logic [3:0]      score_l,
  output logic [3:0]      score_r,
  output logic            point
);

  localparam int CW = cwidth + 1;
  localparam logic [cwidth:0] XMAX_C  = CW'(X_MAX);
  localparam logic [cwidth:0] YMAX_C  = CW'(Y_MAX);
  localparam logic [cwidth:0] LEFT_C  = CW'(LEFT_X);
  localparam logic [cwidth:0] RIGHT_C = CW'(RIGHT_X);

  state_t      state;
  state_t      state_n;
  logic [31:0] hold;
  logic [31:0] hold_n;
  logic        dir_x_n;
  logic        dir_y_n;
  logic [63:0] thr_n;
  logic [3:0]  sl_n;
  logic [3:0]  sr_n;
  logic        point_n;

  logic in_l;
  logic in_r;
  logic hit_l;
  logic hit_r;
  logic left_scores;
  logic right_scores;
  logic hold_done;

  paddle_hit #(
    .cwidth  (cwidth),
    .PADDLE_H(PADDLE_H)
  ) u_hit_l (
    .ball_y  (ball_y),
    .paddle_y(paddle_l),
    .hit     (in_l)
  );

  paddle_hit #(
    .cwidth  (cwidth),
    .PADDLE_H(PADDLE_H)
  ) u_hit_r (
    .ball_y  (ball_y),
    .paddle_y(paddle_r),
    .hit     (in_r)
  );

  assign hit_l = (ball_x == LEFT_C) && !direction_x && in_l;
  assign hit_r = (ball_x == RIGHT_C) && direction_x && in_r;

  // Ball leaving the left edge is a point for the right player.
  assign right_scores = (ball_x == '0) && !direction_x;
  assign left_scores  = (ball_x == XMAX_C) && direction_x;

  // 33-bit compare so a zero hold still leaves after one cycle.
  assign hold_done =
    (({1'b0, hold} + 33'd1) >= {1'b0, SCORE_HOLD});

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SERVE;
      hold        <= '0;
      active      <= 1'b0;
      direction_x <= 1'b1;
      direction_y <= 1'b1;
      threshold   <= THRESH_INIT;
      score_l     <= '0;
      score_r     <= '0;
      point       <= 1'b0;
    end else begin
      state       <= state_n;
      hold        <= hold_n;
      active      <= (state_n == PLAY);
      direction_x <= dir_x_n;
      direction_y <= dir_y_n;
      threshold   <= thr_n;
      score_l     <= sl_n;
      score_r     <= sr_n;
      point       <= point_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SERVE: begin
        if (serve) state_n = PLAY;
      end
      PLAY: begin
        if (left_scores || right_scores)
          state_n = SCORED;
      end
      SCORED: begin
        if (hold_done) state_n = SERVE;
      end
      default: state_n = SERVE;
    endcase
  end

  always_comb begin
    hold_n  = hold;
    dir_x_n = direction_x;
    dir_y_n = direction_y;
    thr_n   = threshold;
    sl_n    = score_l;
    sr_n    = score_r;
    point_n = 1'b0;
    unique case (state)
      SERVE: begin
        hold_n = '0;
        if (serve) thr_n = THRESH_INIT;
      end
      PLAY: begin
        hold_n = '0;
        if ((ball_y == '0) && !direction_y)
          dir_y_n = 1'b1;
        else if ((ball_y == YMAX_C) && direction_y)
          dir_y_n = 1'b0;
        // A miss outranks any paddle hit this cycle.
        if (right_scores) begin
          sr_n    = sat_inc(score_r);
          dir_x_n = 1'b0;
          point_n = 1'b1;
        end else if (left_scores) begin
          sl_n    = sat_inc(score_l);
          dir_x_n = 1'b1;
          point_n = 1'b1;
        end else if (hit_l || hit_r) begin
          dir_x_n = hit_l;
          thr_n   = speed_up(threshold, THRESH_STEP,
                             THRESH_MIN);
        end
      end
      SCORED: begin
        hold_n = hold_done ? '0 : hold + 32'd1;
      end
      default: begin
        hold_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bounce_controller.sv
// Self-checking bench for bounce_controller: vector table, corner sequences
// and randomized play checked against a rule-level reference model.
module tb_bounce_controller;

  localparam int     HOLD  = 10;
  localparam longint INIT  = 500000;
  localparam longint TMIN  = 100000;
  localparam longint TSTEP = 25000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        serve = 1'b0;
  logic [7:0]  ball_x = 8'd80;
  logic [7:0]  ball_y = 8'd60;
  logic [7:0]  paddle_l = 8'd0;
  logic [7:0]  paddle_r = 8'd0;
  logic        active;
  logic        direction_x;
  logic        direction_y;
  logic [63:0] threshold;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        point;

  int checks = 0;
  int errors = 0;

  bounce_controller #(
    .SCORE_HOLD(32'd10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .serve      (serve),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l   (paddle_l),
    .paddle_r   (paddle_r),
    .active     (active),
    .direction_x(direction_x),
    .direction_y(direction_y),
    .threshold  (threshold),
    .score_l    (score_l),
    .score_r    (score_r),
    .point      (point)
  );

  always #5 clock = ~clock;

  // Reference model: playing flag plus freeze countdown.
  bit     m_playing;
  int     m_freeze;
  bit     m_dx;
  bit     m_dy;
  longint m_thr;
  int     m_sl;
  int     m_sr;
  bit     m_point;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  x;
    int  y;
    bit  in_l;
    bit  in_r;
    x = int'(ball_x);
    y = int'(ball_y);
    in_l = (y >= int'(paddle_l)) && (y <= int'(paddle_l) + 15);
    in_r = (y >= int'(paddle_r)) && (y <= int'(paddle_r) + 15);
    if (reset) begin
      m_playing = 0; m_freeze = 0; m_dx = 1; m_dy = 1;
      m_thr = INIT; m_sl = 0; m_sr = 0; m_point = 0;
      return;
    end
    m_point = 0;
    if (m_freeze > 0) begin
      m_freeze--;
    end else if (!m_playing) begin
      if (serve) begin
        m_playing = 1;
        m_thr = INIT;
      end
    end else begin
      if (y == 0 && !m_dy) m_dy = 1;
      else if (y == 119 && m_dy) m_dy = 0;
      if (x == 0 && !m_dx) begin
        m_sr = (m_sr < 15) ? m_sr + 1 : 15;
        m_dx = 0; m_point = 1;
        m_playing = 0; m_freeze = HOLD;
      end else if (x == 159 && m_dx) begin
        m_sl = (m_sl < 15) ? m_sl + 1 : 15;
        m_dx = 1; m_point = 1;
        m_playing = 0; m_freeze = HOLD;
      end else if ((x == 4 && !m_dx && in_l) ||
                   (x == 155 && m_dx && in_r)) begin
        m_dx = !m_dx;
        m_thr = (m_thr - TSTEP < TMIN) ? TMIN : m_thr - TSTEP;
      end
    end
  endtask

  task automatic tick(input bit cmp_model);
    model_edge();
    @(posedge clock);
    #1;
    if (cmp_model) begin
      chk("m_active", active, m_playing);
      chk("m_dir_x", direction_x, m_dx);
      chk("m_dir_y", direction_y, m_dy);
      chk("m_thresh", threshold, m_thr);
      chk("m_score_l", score_l, m_sl);
      chk("m_score_r", score_r, m_sr);
      chk("m_point", point, m_point);
    end
  endtask

  typedef struct {
    bit     rst;
    bit     srv;
    int     bx;
    int     by;
    int     pl;
    int     pr;
    bit     a;
    bit     dx;
    bit     dy;
    longint thr;
    int     sl;
    int     sr;
    bit     pt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 0,  80,  60,  0,   0, 0, 1, 1, 500000, 0, 0, 0};
    tbl[1]  = '{0, 1,  80,  60,  0,   0, 1, 1, 1, 500000, 0, 0, 0};
    tbl[2]  = '{0, 0,  80, 119,  0,   0, 1, 1, 0, 500000, 0, 0, 0};
    tbl[3]  = '{0, 0,  80, 119,  0,   0, 1, 1, 0, 500000, 0, 0, 0};
    tbl[4]  = '{0, 0,  80, 119,  0,   0, 1, 1, 0, 500000, 0, 0, 0};
    tbl[5]  = '{0, 0, 155,  40,  0,  30, 1, 0, 0, 475000, 0, 0, 0};
    tbl[6]  = '{0, 0,   4,  40, 30,  30, 1, 1, 0, 450000, 0, 0, 0};
    tbl[7]  = '{0, 0,   4,  40, 30,  30, 1, 1, 0, 450000, 0, 0, 0};
    tbl[8]  = '{0, 0, 155,  45, 30,  30, 1, 0, 0, 425000, 0, 0, 0};
    tbl[9]  = '{0, 0,   4,  46, 30,  30, 1, 0, 0, 425000, 0, 0, 0};
    tbl[10] = '{0, 0,   4,  29, 30,  30, 1, 0, 0, 425000, 0, 0, 0};
    tbl[11] = '{0, 0,   4,  30, 30,  30, 1, 1, 0, 400000, 0, 0, 0};
    tbl[12] = '{0, 0,  80,   0,  0,   0, 1, 1, 1, 400000, 0, 0, 0};
    tbl[13] = '{0, 0, 159,  50,  0, 100, 0, 1, 1, 400000, 1, 0, 1};
    tbl[14] = '{0, 0,  80,  50,  0, 100, 0, 1, 1, 400000, 1, 0, 0};

    for (int i = 0; i < 15; i++) begin
      reset    = tbl[i].rst;
      serve    = tbl[i].srv;
      ball_x   = 8'(tbl[i].bx);
      ball_y   = 8'(tbl[i].by);
      paddle_l = 8'(tbl[i].pl);
      paddle_r = 8'(tbl[i].pr);
      tick(1'b0);
      chk($sformatf("v%0d_active", i), active, tbl[i].a);
      chk($sformatf("v%0d_dir_x", i), direction_x, tbl[i].dx);
      chk($sformatf("v%0d_dir_y", i), direction_y, tbl[i].dy);
      chk($sformatf("v%0d_thresh", i), threshold, tbl[i].thr);
      chk($sformatf("v%0d_score_l", i), score_l, tbl[i].sl);
      chk($sformatf("v%0d_score_r", i), score_r, tbl[i].sr);
      chk($sformatf("v%0d_point", i), point, tbl[i].pt);
    end
    reset = 1'b0;

    // Freeze: serve held high is ignored until the hold expires.
    serve  = 1'b1;
    ball_x = 8'd80;
    ball_y = 8'd60;
    for (int k = 2; k <= HOLD; k++) begin
      tick(1'b1);
      chk("hold_active", active, 1'b0);
    end
    tick(1'b1);
    chk("reserve_active", active, 1'b1);
    chk("reserve_thresh", threshold, 64'd500000);
    chk("reserve_dir_x", direction_x, 1'b1);
    serve = 1'b0;

    // Repeated hits down to the speed floor.
    paddle_l = 8'd30;
    paddle_r = 8'd30;
    ball_y   = 8'd40;
    for (int h = 1; h <= 18; h++) begin
      longint e;
      ball_x = (h % 2 == 1) ? 8'd155 : 8'd4;
      tick(1'b1);
      e = INIT - TSTEP * h;
      if (e < TMIN) e = TMIN;
      chk($sformatf("hit%0d_thresh", h), threshold, e);
      chk($sformatf("hit%0d_dir_x", h), direction_x, (h % 2 == 0));
    end

    // Left player reaches 3 points, then reset mid-play.
    for (int s = 2; s <= 3; s++) begin
      ball_x = 8'd159;
      tick(1'b1);
      chk("lscore", score_l, 4'(s));
      chk("lscore_point", point, 1'b1);
      serve  = 1'b1;
      ball_x = 8'd80;
      for (int k = 0; k <= HOLD; k++) tick(1'b1);
      chk("lscore_replay", active, 1'b1);
      serve = 1'b0;
    end
    tick(1'b1);
    reset = 1'b1;
    tick(1'b1);
    chk("rst_active", active, 1'b0);
    chk("rst_dir_x", direction_x, 1'b1);
    chk("rst_dir_y", direction_y, 1'b1);
    chk("rst_thresh", threshold, 64'd500000);
    chk("rst_score_l", score_l, 4'd0);
    chk("rst_score_r", score_r, 4'd0);
    chk("rst_point", point, 1'b0);
    reset = 1'b0;

    // Randomized play against the reference model.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 7));
      case (r)
        0: ball_x = 8'd0;
        1: ball_x = 8'd4;
        2: ball_x = 8'd155;
        3: ball_x = 8'd159;
        default: ball_x = 8'($urandom_range(0, 159));
      endcase
      r = int'($urandom_range(0, 5));
      case (r)
        0: ball_y = 8'd0;
        1: ball_y = 8'd119;
        default: ball_y = 8'($urandom_range(0, 119));
      endcase
      paddle_l = 8'($urandom_range(0, 127));
      paddle_r = 8'($urandom_range(0, 127));
      serve    = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 799) == 0);
      tick(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bounce_controller.md
BOUNCE_CONTROLLER -- requirements
Module: bounce_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- cwidth, 7, coordinate MSB index (coordinates are cwidth+1 bits)
- X_MAX, 159, rightmost x
- Y_MAX, 119, bottom y
- LEFT_X, 4, left paddle face x
- RIGHT_X, 155, right paddle face x
- PADDLE_H, 16, paddle height in pixels
- THRESH_INIT, 64'd500000, serve-speed wait threshold
- THRESH_MIN, 64'd100000, fastest threshold
- THRESH_STEP, 64'd25000, decrement per paddle hit
- SCORE_HOLD, 32'd50000000, cycles frozen after a point
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, sole clock
- reset, in, 1, synchronous active-high reset
- serve, in, 1, level/pulse request to launch the ball
- ball_x, in, cwidth+1, current x from the x-axis mover
- ball_y, in, cwidth+1, current y from the y-axis mover
- paddle_l, in, cwidth+1, left paddle top y
- paddle_r, in, cwidth+1, right paddle top y
- active, out, 1, enable to both movers
- direction_x, out, 1, 1 = +x, 0 = -x
- direction_y, out, 1, 1 = +y, 0 = -y
- threshold, out, 64, wait threshold to both movers
- score_l, out, 4, left player points
- score_r, out, 4, right player points
- point, out, 1, one-cycle pulse on any score

Function
REQ-003 FSM states SHALL be SERVE, PLAY, SCORED; all outputs registered.
REQ-004 SERVE: active=0; serve=1 -> PLAY next cycle, threshold<=THRESH_INIT.
REQ-005 PLAY: active=1; evaluate rules REQ-006..REQ-010 every cycle on current inputs.
REQ-006 Wall: ball_y==0 && direction_y==0 -> direction_y<=1; ball_y==Y_MAX && direction_y==1 -> direction_y<=0; flip only when moving toward the wall (no double flip).
REQ-007 Left hit: ball_x==LEFT_X && direction_x==0 && paddle_l<=ball_y<=paddle_l+PADDLE_H-1 (computed cwidth+2 bits, no wrap) -> direction_x<=1.
REQ-008 Right hit: ball_x==RIGHT_X && direction_x==1 && ball_y within paddle_r span -> direction_x<=0.
REQ-009 Each hit: threshold<=max(threshold-THRESH_STEP, THRESH_MIN), no underflow.
REQ-010 Miss: ball_x==0 && direction_x==0 -> score_r+1; ball_x==X_MAX && direction_x==1 -> score_l+1; point=1 for one cycle; -> SCORED.
REQ-011 Scores SHALL saturate at 15.
REQ-012 Score beats hit in the same cycle; wall and x events in the same cycle both apply.
REQ-013 SCORED: active=0, hold counter counts SCORE_HOLD cycles, then -> SERVE; direction_x<=0 if right scored, 1 if left scored; direction_y unchanged.
REQ-014 serve ignored outside SERVE.

Reset
REQ-015 reset=1 at a clock edge, any state -> SERVE, active=0, direction_x=1, direction_y=1, threshold=THRESH_INIT, score_l=score_r=0, point=0, hold counter=0.

Structure
REQ-016 State enum and default speed constants SHALL live in shared package pong_pkg.
REQ-017 One sub-module paddle_hit (combinational span check, instantiated twice).

Verification
REQ-018 reset, serve=1 one cycle -> next cycle active=1, threshold=500000, direction_x=1.
REQ-019 PLAY, ball_y=119, direction_y=1 held 3 cycles -> direction_y=0 after one edge, stays 0.
REQ-020 ball_x=155, ball_y=40, paddle_r=30, dir_x=1 -> direction_x=0, threshold=475000; 16 hits -> threshold=100000.
REQ-021 ball_x=159, dir_x=1, paddle_r=100 -> score_l=1, point one cycle, active=0; SCORE_HOLD=10 -> SERVE after 10 cycles, direction_x=1.
REQ-022 reset asserted mid-PLAY with score_l=3 -> all REQ-015 values next cycle.
